// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
//
// Single-port frame-buffer arbiter between a CSI pixel writer and an HDMI line
// prefetcher. Reads are served as fixed BURST_LEN bursts. Writes are served one
// beat per cycle for up to BURST_LEN beats per grant. An urgent read (line FIFO
// starving) preempts any write in progress. Otherwise contention is resolved
// round-robin, starting with the writer after reset.
//
// Optional feature: define FB_ARB_STATS_EN to build a saturating write-stall
// counter. Without it, wr_stall_cnt is tied to zero.
//
// Ports
//   clk_low       in   1        sole clock, rising edge
//   reset_n       in   1        asynchronous active-low reset
//   wr_req        in   1        writer has a pixel pending (held until wr_ack)
//   wr_addr       in   ADDR_W   pixel write address
//   wr_data       in   24       RGB888 pixel
//   wr_ack        out  1        current write beat consumed this cycle
//   rd_req        in   1        prefetcher requests one burst (held until rd_gnt)
//   rd_addr       in   ADDR_W   burst start address, sampled on rd_gnt
//   rd_urgent     in   1        line FIFO below low-water mark
//   rd_gnt        out  1        one-cycle pulse accepting rd_req
//   rd_data       out  24       returned pixel, valid with rd_valid
//   rd_valid      out  1        one pulse per returned beat
//   rd_done       out  1        marks the last beat of a burst
//   mem_en        out  1        RAM access strobe
//   mem_we        out  1        RAM write enable
//   mem_addr      out  ADDR_W   RAM address
//   mem_wdata     out  24       RAM write data
//   mem_rdata     in   24       RAM read data, one cycle after the access
//   wr_stall_cnt  out  16       cycles with wr_req=1 and wr_ack=0 (saturating)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fb_arbiter #(
    parameter int ADDR_W    = 21,
    parameter int FB_DEPTH  = 307200,
    parameter int BURST_LEN = 16
) (
    input  logic              clk_low,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_urgent,
    output logic              rd_gnt,
    output logic [23:0]       rd_data,
    output logic              rd_valid,
    output logic              rd_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata,
    output logic [15:0]       wr_stall_cnt
);

    localparam int                BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rr_rd_q;      // 1: reader wins the next contended arbitration
    logic [BEAT_W-1:0]   beat_q;       // beats issued in the current grant
    logic [ADDR_W-1:0]   addr_q;       // next read address after the first beat
    logic                rd_pend_q;    // a read was issued last cycle
    logic                go_wr, go_rd;

    logic                urgent;
    logic                rd_first;
    logic [ADDR_W-1:0]   rd_cur_addr;
    logic [ADDR_W-1:0]   rd_next_addr;
    logic                wr_in_range;

    assign urgent      = rd_urgent & rd_req;
    // The grant cycle is the first RD cycle, so rd_addr is used directly there
    // and only the follow-on addresses come from addr_q.
    assign rd_first    = (state_q == RD) && (beat_q == '0);
    assign rd_cur_addr = rd_first ? rd_addr : addr_q;
    assign rd_next_addr = (rd_cur_addr == LAST_ADDR) ? '0 : rd_cur_addr + 1'b1;
    assign wr_in_range = (wr_addr <= LAST_ADDR);

    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        go_wr     = 1'b0;
        go_rd     = 1'b0;
        wr_ack    = 1'b0;
        rd_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (urgent) begin
                    go_rd = 1'b1;
                end else if (wr_req && rd_req) begin
                    go_rd = rr_rd_q;
                    go_wr = !rr_rd_q;
                end else if (wr_req) begin
                    go_wr = 1'b1;
                end else if (rd_req) begin
                    go_rd = 1'b1;
                end
                if (go_rd) begin
                    state_d = RD;
                end else if (go_wr) begin
                    state_d = WR;
                end
            end

            WR: begin
                // An urgent read preempts before the beat is taken, so the
                // pixel stays pending and is written after the read burst.
                if (!wr_req || urgent) begin
                    state_d = IDLE;
                end else begin
                    wr_ack = 1'b1;
                    // Out-of-range pixels are consumed but dropped.
                    if (wr_in_range) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = wr_addr;
                        mem_wdata = wr_data;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end

            RD: begin
                rd_gnt   = rd_first;
                mem_en   = 1'b1;
                mem_addr = rd_cur_addr;
                if (beat_q == LAST_BEAT) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_rd_q   <= 1'b0;
            beat_q    <= '0;
            addr_q    <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= (state_q == RD);

            if (go_wr) begin
                rr_rd_q <= 1'b1;
            end else if (go_rd) begin
                rr_rd_q <= 1'b0;
            end

            case (state_q)
                WR:      if (wr_ack) beat_q <= beat_q + 1'b1;
                RD:      beat_q <= beat_q + 1'b1;
                default: beat_q <= '0;
            endcase

            if (state_q == RD) begin
                addr_q <= rd_next_addr;
            end
        end
    end

    // The RAM's own output register provides the one-cycle read latency, so the
    // beat is presented straight from mem_rdata while the pending flag is set.
    assign rd_valid = rd_pend_q;
    assign rd_data  = rd_pend_q ? mem_rdata : 24'h0;
    assign rd_done  = rd_pend_q && (state_q == DRAIN);

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 16'h0;
        end else if (wr_req && !wr_ack && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign wr_stall_cnt = stall_q;
`else
    assign wr_stall_cnt = 16'h0;
`endif

endmodule
